// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Automated instruction source for the Control block. Holds a
//            small program memory loaded while idle and, on start, steps each
//            word through the IF -> ID -> EX person handshake with a fixed
//            dwell per phase, then raises a sticky done flag.
// Options  : SEQ_HALT_WORD_EN - opcode 6'b111111 ends the run before the
//            word is presented.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DWELL  = 4
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [15:0]       load_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              abort,
   output logic [15:0]       instruction,
   output logic [1:0]        person,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   retired,
   output logic              busy,
   output logic              done
);

   localparam int                c_DEPTH      = 1 << ADDR_W;
   localparam logic [7:0]        c_DWELL_LOAD = 8'(DWELL - 1);
   localparam logic [ADDR_W:0]   c_DEPTH_LEN  = (ADDR_W + 1)'(c_DEPTH);
   localparam logic [1:0]        c_P_FETCH    = 2'b00;
   localparam logic [1:0]        c_P_DECODE   = 2'b01;
   localparam logic [1:0]        c_P_EXEC     = 2'b10;
   localparam logic [5:0]        c_HALT_OP    = 6'b111111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DECODE = 2'd2,
      S_EXEC   = 2'd3
   } state_t;

   // Program memory: deliberately outside the reset domain so a reset
   // mid-run leaves the loaded program intact.
   logic [15:0]       r_mem [0:c_DEPTH-1];

   state_t            r_state,  w_state_n;
   logic [7:0]        r_dwell,  w_dwell_n;
   logic [ADDR_W:0]   r_len,    w_len_n;
   logic [15:0]       r_instr,  w_instr_n;
   logic [1:0]        r_person, w_person_n;
   logic [ADDR_W-1:0] r_pc,     w_pc_n;
   logic [ADDR_W:0]   r_ret,    w_ret_n;
   logic              r_busy,   w_busy_n;
   logic              r_done,   w_done_n;
   logic              w_mem_we;

   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W:0]   w_pc_inc_ext;
   logic [15:0]       w_next_word;
   logic [ADDR_W:0]   w_len_clamped;
   logic              w_halt_first;
   logic              w_halt_next;

   assign w_pc_inc      = r_pc + ADDR_W'(1);
   assign w_pc_inc_ext  = {1'b0, r_pc} + (ADDR_W + 1)'(1);
   assign w_next_word   = r_mem[w_pc_inc];
   // A length beyond the memory depth would never match pc+1; cap it so
   // such a run still terminates after the last word.
   assign w_len_clamped = (prog_len > c_DEPTH_LEN) ? c_DEPTH_LEN : prog_len;

`ifdef SEQ_HALT_WORD_EN
   assign w_halt_first = (r_mem[0][15:10] == c_HALT_OP);
   assign w_halt_next  = (w_next_word[15:10] == c_HALT_OP);
`else
   assign w_halt_first = 1'b0;
   assign w_halt_next  = 1'b0;
`endif

   // Next-state and next-output decode; everything holds unless a case moves it.
   always_comb begin
      w_state_n  = r_state;
      w_dwell_n  = r_dwell;
      w_len_n    = r_len;
      w_instr_n  = r_instr;
      w_person_n = r_person;
      w_pc_n     = r_pc;
      w_ret_n    = r_ret;
      w_busy_n   = r_busy;
      w_done_n   = r_done;
      w_mem_we   = 1'b0;

      if (abort) begin
         w_state_n  = S_IDLE;
         w_person_n = c_P_FETCH;
         w_busy_n   = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (load_en) begin
                  w_mem_we = 1'b1;
               end else if (start) begin
                  if (prog_len == '0) begin
                     w_done_n = 1'b1;
                  end else if (w_halt_first) begin
                     // Run ends before anything is presented.
                     w_pc_n     = '0;
                     w_ret_n    = '0;
                     w_done_n   = 1'b1;
                     w_person_n = c_P_FETCH;
                  end else begin
                     w_len_n    = w_len_clamped;
                     w_pc_n     = '0;
                     w_ret_n    = '0;
                     w_done_n   = 1'b0;
                     w_busy_n   = 1'b1;
                     w_instr_n  = r_mem[0];
                     w_person_n = c_P_FETCH;
                     w_dwell_n  = c_DWELL_LOAD;
                     w_state_n  = S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (r_dwell == 8'd0) begin
                  w_state_n  = S_DECODE;
                  w_person_n = c_P_DECODE;
                  w_dwell_n  = c_DWELL_LOAD;
               end else begin
                  w_dwell_n = r_dwell - 8'd1;
               end
            end

            S_DECODE: begin
               if (r_dwell == 8'd0) begin
                  w_state_n  = S_EXEC;
                  w_person_n = c_P_EXEC;
                  w_dwell_n  = c_DWELL_LOAD;
               end else begin
                  w_dwell_n = r_dwell - 8'd1;
               end
            end

            S_EXEC: begin
               if (r_dwell == 8'd0) begin
                  w_ret_n    = r_ret + (ADDR_W + 1)'(1);
                  w_person_n = c_P_FETCH;
                  if ((w_pc_inc_ext == r_len) || w_halt_next) begin
                     w_state_n = S_IDLE;
                     w_busy_n  = 1'b0;
                     w_done_n  = 1'b1;
                  end else begin
                     w_pc_n    = w_pc_inc;
                     w_instr_n = w_next_word;
                     w_dwell_n = c_DWELL_LOAD;
                     w_state_n = S_FETCH;
                  end
               end else begin
                  w_dwell_n = r_dwell - 8'd1;
               end
            end

            default: begin
               w_state_n = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_dwell  <= '0;
         r_len    <= '0;
         r_instr  <= '0;
         r_person <= c_P_FETCH;
         r_pc     <= '0;
         r_ret    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_dwell  <= w_dwell_n;
         r_len    <= w_len_n;
         r_instr  <= w_instr_n;
         r_person <= w_person_n;
         r_pc     <= w_pc_n;
         r_ret    <= w_ret_n;
         r_busy   <= w_busy_n;
         r_done   <= w_done_n;
      end
   end

   // Program memory write port, only enabled from IDLE.
   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         r_mem[load_addr] <= load_data;
      end
   end

   assign instruction = r_instr;
   assign person      = r_person;
   assign pc          = r_pc;
   assign retired     = r_ret;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Directed self-checking bench for instr_sequencer (DWELL = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

   localparam int AW = 4;
   localparam int DW = 4;

   logic          CLK;
   logic          rst;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [15:0]   load_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic          abort;
   logic [15:0]   instruction;
   logic [1:0]    person;
   logic [AW-1:0] pc;
   logic [AW:0]   retired;
   logic          busy;
   logic          done;

   int            total;
   int            bad;
   logic [15:0]   exp_w [0:3];

   instr_sequencer #(.ADDR_W(AW), .DWELL(DW)) dut (
      .CLK         (CLK),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .prog_len    (prog_len),
      .start       (start),
      .abort       (abort),
      .instruction (instruction),
      .person      (person),
      .pc          (pc),
      .retired     (retired),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   // Start was accepted at the edge just ticked (k = 0); follow the run to the end.
   task automatic run_words(input int n, input bit inject);
      for (int k = 0; k < 3 * DW * n; k++) begin
         if (k > 0) begin
            if (inject && k == 1) begin
               load_en   = 1'b1;
               load_addr = 4'd1;
               load_data = 16'h1234;
            end
            if (inject && k == 20) begin
               start    = 1'b1;
               prog_len = 5'd5;
            end
            tick();
            load_en = 1'b0;
            start   = 1'b0;
         end
         chk("run_person", person, 32'((k % (3 * DW)) / DW));
         chk("run_instr", instruction, exp_w[k / (3 * DW)]);
         chk("run_busy", busy, 1);
         chk("run_pc", pc, k / (3 * DW));
         chk("run_retired", retired, k / (3 * DW));
      end
      tick();
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_retired", retired, n);
      chk("end_pc", pc, n - 1);
      chk("end_person", person, 0);
      chk("end_instr", instruction, exp_w[n - 1]);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      prog_len  = '0;
      start     = 1'b0;
      abort     = 1'b0;

      // Reset values
      repeat (2) tick();
      chk("rst_instr", instruction, 0);
      chk("rst_person", person, 0);
      chk("rst_pc", pc, 0);
      chk("rst_retired", retired, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;
      tick();

      // Load program; outputs must hold
      load_word(4'd0, 16'h0016);
      load_word(4'd1, 16'h00E0);
      load_word(4'd2, 16'h0000);
      chk("load_busy", busy, 0);
      chk("load_instr", instruction, 0);
      chk("load_person", person, 0);
      exp_w[0] = 16'h0016;
      exp_w[1] = 16'h00E0;
      exp_w[2] = 16'h0000;
      exp_w[3] = 16'h0000;

      // Three-word run with ignored load and ignored restart mid-run
      prog_len = 5'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      run_words(3, 1'b1);

      // Abort during DECODE of word 1
      prog_len = 5'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("ab_done_clr", done, 0);
      chk("ab_busy", busy, 1);
      repeat (17) tick();
      chk("ab_pre_person", person, 1);
      chk("ab_pre_pc", pc, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_person", person, 0);
      chk("ab_busy_lo", busy, 0);
      chk("ab_done", done, 0);
      chk("ab_retired", retired, 1);
      chk("ab_pc", pc, 1);
      chk("ab_instr", instruction, 16'h00E0);
      tick();
      chk("ab_stay_idle", busy, 0);

      // Zero-length start
      prog_len = 5'd0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_person", person, 0);
      chk("z_retired", retired, 1);
      tick();
      chk("z_busy2", busy, 0);

      // Start held high restarts on the edge after completion
      prog_len = 5'd1;
      start    = 1'b1;
      tick();
      chk("h_busy", busy, 1);
      chk("h_done", done, 0);
      repeat (11) tick();
      chk("h_busy11", busy, 1);
      tick();
      chk("h_end_busy", busy, 0);
      chk("h_end_done", done, 1);
      chk("h_end_ret", retired, 1);
      chk("h_end_pc", pc, 0);
      tick();
      chk("h_re_busy", busy, 1);
      chk("h_re_done", done, 0);
      chk("h_re_ret", retired, 0);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Asynchronous reset during EXEC of word 0
      prog_len = 5'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("r_pre_person", person, 2);
      #2 rst = 1'b0;
      #1;
      chk("ar_instr", instruction, 0);
      chk("ar_pc", pc, 0);
      chk("ar_busy", busy, 0);
      chk("ar_person", person, 0);
      chk("ar_retired", retired, 0);
      chk("ar_done", done, 0);
      #1 rst = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_words(3, 1'b0);

      // Halt-word program
      load_word(4'd1, 16'hFC00);
      load_word(4'd3, 16'h4321);
      prog_len = 5'd4;
      start    = 1'b1;
      tick();
      start = 1'b0;
`ifdef SEQ_HALT_WORD_EN
      chk("hw_busy", busy, 1);
      chk("hw_instr0", instruction, 16'h0016);
      repeat (11) tick();
      chk("hw_busy11", busy, 1);
      tick();
      chk("hw_done", done, 1);
      chk("hw_busy_lo", busy, 0);
      chk("hw_retired", retired, 1);
      chk("hw_instr", instruction, 16'h0016);
      chk("hw_person", person, 0);
      chk("hw_pc", pc, 0);
`else
      exp_w[1] = 16'hFC00;
      exp_w[3] = 16'h4321;
      run_words(4, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

- Automated instruction source that drives the `Control` block's `instruction[15:0]` and `person[1:0]` inputs in place of the switches and the human operator.
- Holds a small program memory, loaded word by word while idle.
- On `start`, it steps each word through the IF→ID→EX handshake (`person` = 00, 01, 10) with a fixed dwell per phase, then stops and flags `done`.

## Interface
- `ADDR_W`, 4: program address width; depth = 2**ADDR_W words of 16 bits.
- `DWELL`, 4: cycles spent in each phase; legal range 2..255.
- `CLK`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `load_en`  in  1  write `load_data` to `mem[load_addr]` this edge; honoured only in IDLE.
- `load_addr`  in  ADDR_W  write address.
- `load_data`  in  16  instruction word to store.
- `prog_len`  in  ADDR_W+1  number of words to run; sampled when `start` is accepted.
- `start`  in  1  level-sampled run request; honoured only in IDLE with `load_en`=0.
- `abort`  in  1  synchronous abort; has priority over everything except reset.
- `instruction`  out  16  registered word presented to `Control`.
- `person`  out  2  registered phase code to `Control`.
- `pc`  out  ADDR_W  address of the word currently presented.
- `retired`  out  ADDR_W+1  count of words completed in the current run.
- `busy`  out  1  high from start acceptance until the run ends.
- `done`  out  1  sticky completion flag; cleared by the next accepted start.

## Operation
- States: IDLE, FETCH (`person`=00), DECODE (`person`=01), EXEC (`person`=10).
- Dwell counter: 8 bits, loaded with DWELL−1 on state entry, decremented each cycle; the phase advances when it reaches 0.
- IDLE
  - `load_en`: `mem[load_addr]` is written; all outputs hold.
  - `start` with `prog_len`=0: `done`←1; `busy` stays 0.
  - `start` with `prog_len`>0: latch `prog_len`; `pc`←0, `retired`←0, `done`←0, `busy`←1; `instruction`←`mem[0]`, `person`←00; go to FETCH.
- FETCH→DECODE→EXEC: `person` changes on each phase advance; `instruction` is stable for the whole instruction.
- End of EXEC:
  - `retired`←`retired`+1.
  - If `pc`+1 == latched length: go to IDLE with `person`←00, `busy`←0, `done`←1. `instruction` and `pc` hold.
  - Otherwise: `pc`←`pc`+1, `instruction`←`mem[pc+1]`, `person`←00, go to FETCH.
- `abort` in any state: IDLE, `person`←00, `busy`←0, `done` unchanged. `pc`, `retired` and `instruction` hold.
- Ignored inputs:
  - `load_en` while busy (memory is unchanged).
  - `start` while busy, or while `load_en`=1.
  - `prog_len` changes after acceptance.
- Memory is not reset. Its contents survive `rst`.
- Reset values: `instruction`=0, `person`=00, `pc`=0, `retired`=0, `busy`=0, `done`=0, state IDLE.

## Timing
- Start accepted at edge T: at T `busy`=1 and `instruction`=`mem[0]`. `person` is 01 from T+DWELL and 10 from T+2·DWELL.
- Per instruction: exactly 3·DWELL cycles.
- N-word run: `busy` falls and `done` rises at T+3·DWELL·N.
- `person` never skips a code. Each code is held at least DWELL ≥ 2 cycles, which covers `Control`'s two-cycle decode.
- `start` held high after completion starts a new run on the following edge.
- Reset mid-run: all outputs return to reset values immediately (asynchronous). Memory holds.

## Configuration
- `SEQ_HALT_WORD_EN` defined:
  - Whenever a word is about to be presented (at start and at each end of EXEC), its opcode bits [15:10] are checked.
  - If they equal 6'b111111, the run ends as a normal completion instead: IDLE, `busy`←0, `done`←1, `person`←00.
  - The halt word is never presented and is not counted in `retired`.
  - `instruction` keeps its previous value.
- Not defined: opcode 111111 is an ordinary word; runs end only on `prog_len`.

## Test plan
- Load `mem[0..2]` = 16'h0016, 16'h00E0, 16'h0000; start with `prog_len`=3, DWELL=4.
  - Required: `person` sequence 00,01,10 ×3, each held 4 cycles.
  - Required: `done` at T+36, `retired`=3, `pc`=2.
- Start with `prog_len`=0 → `done`=1 one edge later; `busy` never rises; `person` stays 00.
- Mid-run stimuli:
  - `load_en` to `mem[1]` during the first FETCH → memory unchanged; word 1 presents the original value.
  - Second `start` mid-run → ignored; total run length unchanged.
- `abort` during DECODE of word 1 → next edge: IDLE, `person`=00, `busy`=0, `done`=0, `retired`=1.
- Assert `rst`=0 in EXEC → `instruction`=0, `pc`=0, `busy`=0 without waiting for a clock edge. Then restart → the previously loaded program runs intact.
- With `SEQ_HALT_WORD_EN`: `mem[1]`=16'hFC00, `prog_len`=4.
  - Required: `done` after one instruction, `retired`=1, `instruction` stays `mem[0]`.
  - Without the macro: all 4 words are presented.
